// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM tile store.
//   wr_state_e         : write-path FSM states (IDLE, FILL, COMMIT)
//   DEF_BEAT_W/BEATS/DEPTH : default geometry used by the modules' parameters
//   tile_w()           : full tile width from beat width and beat count
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } wr_state_e;

  localparam int DEF_BEAT_W = 16;
  localparam int DEF_BEATS  = 16;
  localparam int DEF_DEPTH  = 2048;

  function automatic int tile_w(input int beat_w, input int beats);
    return beat_w * beats;
  endfunction

endpackage

// File: rtl/vram_beat_assembler.sv
// Burst assembler for the VRAM tile store write path.
// Collects BEATS handshaked beats into one tile word (beat 0 in the MSBs),
// then spends one COMMIT cycle presenting the tile for an atomic array write.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   wr_valid/wr_ready     : beat handshake (ready low only in COMMIT)
//   wr_first, wr_tile     : burst start marker and destination index
//   wr_data               : beat payload
//   tile, tile_idx, tile_we : assembled tile, its index, write strobe (= commit)
//   burst_err             : one-cycle pulse, registered, after a bad first-beat marker
module vram_beat_assembler
  import vram_pkg::*;
#(
  parameter  int BEAT_W = DEF_BEAT_W,
  parameter  int BEATS  = DEF_BEATS,
  parameter  int AW     = $clog2(DEF_DEPTH),
  localparam int TILE_W = tile_w(BEAT_W, BEATS),
  localparam int CW     = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_first,
  input  logic [AW-1:0]     wr_tile,
  input  logic [BEAT_W-1:0] wr_data,
  output logic [TILE_W-1:0] tile,
  output logic [AW-1:0]     tile_idx,
  output logic              tile_we,
  output logic              burst_err
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  wr_state_e state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] slot_sel;
  logic [AW-1:0] idx;
  logic          acc, load, err_nxt;

  // Ascending packed range puts slot 0 in the MSBs of the flattened tile.
  logic [0:BEATS-1][BEAT_W-1:0] slot;

  assign wr_ready = (state != COMMIT);
  assign acc      = wr_valid && (state != COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    slot_sel  = cnt;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (wr_first) begin
            load      = 1'b1;
            slot_sel  = '0;
            state_nxt = FILL;
          end else begin
            err_nxt = 1'b1;   // stray beat: dropped
          end
        end
      end
      FILL: begin
        if (acc) begin
          load = 1'b1;
          if (wr_first) begin
            // restart: partial tile abandoned, new burst begins in slot 0
            slot_sel = '0;
            err_nxt  = 1'b1;
          end else if (cnt == LAST) begin
            state_nxt = COMMIT;
          end
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      burst_err <= 1'b0;
    end else begin
      burst_err <= err_nxt;
      if (load) begin
        if (wr_first) begin
          idx <= wr_tile;
          cnt <= CW'(1);
        end else if (cnt != LAST) begin
          cnt <= cnt + CW'(1);
        end
      end
      if (state == COMMIT) cnt <= '0;
    end
  end

  // Slot storage is pure datapath; every slot is rewritten before a commit.
  always_ff @(posedge clk) begin
    if (load) slot[slot_sel] <= wr_data;
  end

  assign tile     = slot;
  assign tile_idx = idx;
  assign tile_we  = (state == COMMIT);

endmodule

// File: rtl/vram_tile_store.sv
// VRAM tile store: burst-assembled tile writes into an on-chip array with
// RD_PORTS independent registered read ports.
// Optional feature macro VRAM_TILE_BYPASS_EN: a read of the committing tile
// in the COMMIT cycle returns the new tile (write-first). Without it the read
// returns the old contents (read-first), which maps to plain block RAM.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_first/wr_tile/wr_data : beat write channel
//   commit, commit_tile            : one-cycle pulse + index of each array write
//   burst_err                      : one-cycle protocol-violation pulse
//   rd_en, rd_addr (packed AW/port): read requests
//   rd_data (packed TILE_W/port), rd_valid : read response, 1 cycle later
module vram_tile_store
  import vram_pkg::*;
#(
  parameter  int BEAT_W   = DEF_BEAT_W,
  parameter  int BEATS    = DEF_BEATS,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int RD_PORTS = 2,
  localparam int TILE_W   = tile_w(BEAT_W, BEATS),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic                         wr_first,
  input  logic [AW-1:0]                wr_tile,
  input  logic [BEAT_W-1:0]            wr_data,
  output logic                         commit,
  output logic [AW-1:0]                commit_tile,
  output logic                         burst_err,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*TILE_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_valid
);

  logic [TILE_W-1:0] mem [DEPTH];

  logic [TILE_W-1:0] asm_tile;
  logic [AW-1:0]     asm_idx;
  logic              asm_we;

  vram_beat_assembler #(
    .BEAT_W (BEAT_W),
    .BEATS  (BEATS),
    .AW     (AW)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_first  (wr_first),
    .wr_tile   (wr_tile),
    .wr_data   (wr_data),
    .tile      (asm_tile),
    .tile_idx  (asm_idx),
    .tile_we   (asm_we),
    .burst_err (burst_err)
  );

  assign commit      = asm_we;
  assign commit_tile = asm_idx;

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (asm_we) mem[asm_idx] <= asm_tile;
  end

  logic [RD_PORTS-1:0][TILE_W-1:0] rd_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [TILE_W-1:0] word;
    logic [TILE_W-1:0] q;
    logic              v;

    assign addr = rd_addr[p*AW +: AW];

`ifdef VRAM_TILE_BYPASS_EN
    assign word = (asm_we && (addr == asm_idx)) ? asm_tile : mem[addr];
`else
    assign word = mem[addr];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
        v <= 1'b0;
      end else begin
        v <= rd_en[p];
        if (rd_en[p]) q <= word;   // data holds while the port is idle
      end
    end

    assign rd_q[p]     = q;
    assign rd_valid[p] = v;
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_vram_tile_store.sv
// Scoreboard bench for vram_tile_store (default geometry, 2 read ports).
// Stimulus pushes expected commits, burst errors and read data into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_vram_tile_store;
  localparam int AW = 11;
  localparam int TW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_first;
  logic          wr_ready;
  logic [AW-1:0] wr_tile;
  logic [15:0]   wr_data;
  logic          commit, burst_err;
  logic [AW-1:0] commit_tile;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [2*TW-1:0] rd_data;
  logic [1:0]    rd_valid;

  vram_tile_store dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_first(wr_first),
    .wr_tile(wr_tile), .wr_data(wr_data),
    .commit(commit), .commit_tile(commit_tile), .burst_err(burst_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] commit_q[$];
  logic [TW-1:0] rd_q0[$];
  logic [TW-1:0] rd_q1[$];
  int            err_pend = 0;
  logic          in_commit = 1'b0;
  logic [TW-1:0] model [int];

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  function automatic logic [TW-1:0] ramp(input logic [15:0] base);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < 16; k++) t[TW-1-k*16 -: 16] = base + 16'(k);
    return t;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("wr_ready", TW'(wr_ready), TW'(!in_commit));
        chk("commit_timing", TW'(commit), TW'(in_commit));
        if (commit) begin
          if (commit_q.size() == 0) flag("commit_unexpected");
          else chk("commit_tile", TW'(commit_tile), TW'(commit_q.pop_front()));
        end
        if (burst_err) begin
          if (err_pend == 0) flag("burst_err_unexpected");
          else begin total++; err_pend--; end
        end
        if (rd_valid[0]) begin
          if (rd_q0.size() == 0) flag("rd0_unexpected");
          else chk("rd_data0", rd_data[0 +: TW], rd_q0.pop_front());
        end
        if (rd_valid[1]) begin
          if (rd_q1.size() == 0) flag("rd1_unexpected");
          else chk("rd_data1", rd_data[TW +: TW], rd_q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic send_beat(input logic first, input logic [AW-1:0] t, input logic [15:0] d);
    wr_valid = 1'b1; wr_first = first; wr_tile = t; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_first = 1'b0;
  endtask

  task automatic burst(input logic [AW-1:0] t, input logic [15:0] base, input int gap, input bit coll);
    logic [TW-1:0] old5;
    for (int k = 0; k < 16; k++) begin
      send_beat(k == 0, t, base + 16'(k));
      if (k < 15) repeat (gap) begin @(posedge clk); #1; end
    end
    // now in the COMMIT cycle
    in_commit = 1'b1;
    commit_q.push_back(t);
    if (coll) begin
      old5 = model[5];
      rd_en = 2'b11;
      rd_addr = {AW'(6), AW'(5)};
      rd_q1.push_back(model[6]);
`ifdef VRAM_TILE_BYPASS_EN
      rd_q0.push_back(ramp(base));
`else
      rd_q0.push_back(old5);
`endif
    end
    model[int'(t)] = ramp(base);
    @(posedge clk); #1;
    in_commit = 1'b0;
    rd_en = 2'b00;
  endtask

  task automatic do_read(input bit e0, input logic [AW-1:0] a0, input bit e1, input logic [AW-1:0] a1);
    rd_en = {e1, e0};
    rd_addr = {a1, a0};
    if (e0) rd_q0.push_back(model[int'(a0)]);
    if (e1) rd_q1.push_back(model[int'(a1)]);
    @(posedge clk); #1;
    rd_en = 2'b00;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_first = 1'b0; wr_tile = '0; wr_data = '0;
    rd_en = 2'b00; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", TW'(wr_ready), TW'(1));
    chk("rst_commit", TW'(commit), TW'(0));
    chk("rst_commit_tile", TW'(commit_tile), TW'(0));
    chk("rst_burst_err", TW'(burst_err), TW'(0));
    chk("rst_rd_valid", TW'(rd_valid), TW'(0));
    chk("rst_rd_data0", rd_data[0 +: TW], '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // tile 5, ramp 0x0001..0x0010, back-to-back
    burst(5, 16'h0001, 0, 1'b0);
    rd_en = 2'b01; rd_addr = {AW'(0), AW'(5)};
    rd_q0.push_back(256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000a_000b_000c_000d_000e_000f_0010);
    @(posedge clk); #1;
    rd_en = 2'b00;

    // tile 3 with 3-cycle gaps, same data
    burst(3, 16'h0001, 3, 1'b0);
    do_read(1'b1, 3, 1'b1, 5);

    // tiles 6 and 9 preloaded
    burst(6, 16'h6000, 0, 1'b0);
    burst(9, 16'h9000, 0, 1'b0);

    // tile 9 restarted at beat 7 by a full burst to tile 10
    for (int k = 0; k < 7; k++) send_beat(k == 0, 9, 16'hA000 + 16'(k));
    err_pend++;
    burst(10, 16'hB000, 0, 1'b0);
    do_read(1'b1, 9, 1'b1, 10);

    // stray beat in IDLE, then a full burst must still take exactly 16 beats
    err_pend++;
    send_beat(1'b0, 7, 16'h1234);
    repeat (2) begin @(posedge clk); #1; end
    burst(7, 16'h7000, 1, 1'b0);
    do_read(1'b0, 0, 1'b1, 7);

    // commit to 5 collides with reads of 5 (port 0) and 6 (port 1)
    burst(5, 16'hC000, 0, 1'b1);
    do_read(1'b1, 5, 1'b0, 0);

    // reset in the middle of a tile-3 burst
    for (int k = 0; k < 8; k++) send_beat(k == 0, 3, 16'hD000 + 16'(k));
    rst = 1'b1;
    #1;
    chk("midrst_wr_ready", TW'(wr_ready), TW'(1));
    chk("midrst_commit", TW'(commit), TW'(0));
    chk("midrst_burst_err", TW'(burst_err), TW'(0));
    chk("midrst_rd_valid", TW'(rd_valid), TW'(0));
    chk("midrst_rd_data0", rd_data[0 +: TW], '0);
    chk("midrst_rd_data1", rd_data[TW +: TW], '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(1'b1, 3, 1'b1, 10);

    repeat (4) begin @(posedge clk); #1; end
    chk("commit_q_drained", TW'(commit_q.size()), TW'(0));
    chk("burst_err_seen", TW'(err_pend), TW'(0));
    chk("rd0_drained", TW'(rd_q0.size()), TW'(0));
    chk("rd1_drained", TW'(rd_q1.size()), TW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
